// File: rtl/aes_word_loader.sv
// aes_word_loader: 32-bit valid/ready word stream wrapper around the aes_128 core.
// Optional macro AES_LOADER_KEY_REUSE_EN lets a block keep the previously loaded key.
module aes_word_loader #(
  parameter int LATENCY = 21,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key_keep,
  output logic [127:0] aes_state,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_out,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } st_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  st_t              st;
  logic [127:0]     key_r;
  logic [127:0]     state_r;
  logic [127:0]     res_r;
  logic [2:0]       word_cnt;
  logic [CNT_W-1:0] wait_cnt;

`ifndef AES_LOADER_KEY_REUSE_EN
  logic unused_key_keep;
  assign unused_key_keep = in_key_keep;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= LOAD;
      key_r    <= '0;
      state_r  <= '0;
      res_r    <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (st)
        LOAD: begin
          if (in_valid) begin
`ifdef AES_LOADER_KEY_REUSE_EN
            // Keep the old key: this word is plaintext word 0.
            if (word_cnt == 3'd0 && in_key_keep) begin
              state_r  <= {state_r[95:0], in_data};
              word_cnt <= 3'd5;
            end else
`endif
            begin
              if (word_cnt[2])
                state_r <= {state_r[95:0], in_data};
              else
                key_r <= {key_r[95:0], in_data};
              if (word_cnt == 3'd7) begin
                word_cnt <= '0;
                st       <= WAIT;
              end else begin
                word_cnt <= word_cnt + 3'd1;
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt == LAT_M1) begin
            res_r    <= aes_out;
            wait_cnt <= '0;
            st       <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            res_r <= {res_r[95:0], 32'h0};
            if (word_cnt == 3'd3) begin
              word_cnt <= '0;
              st       <= LOAD;
            end else begin
              word_cnt <= word_cnt + 3'd1;
            end
          end
        end
        default: st <= LOAD;
      endcase
    end
  end

  assign in_ready  = (st == LOAD);
  assign busy      = (st != LOAD);
  assign out_valid = (st == DRAIN);
  assign out_data  = res_r[127:96];
  assign aes_key   = key_r;
  assign aes_state = state_r;

endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: drives aes_word_loader around a software AES-128 core
// model with a fixed pipeline delay and checks the returned ciphertext words.
module tb_aes_word_loader;

  localparam int LATENCY = 21;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_key_keep;
  logic [127:0] aes_state;
  logic [127:0] aes_key;
  logic [127:0] aes_out;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [127:0] pipe [LATENCY-1];

  aes_word_loader #(.LATENCY(LATENCY), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_key_keep(in_key_keep),
    .aes_state(aes_state), .aes_key(aes_key), .aes_out(aes_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      b = inv;
      sb[x] = b ^ rl(b) ^ rl(rl(b)) ^ rl(rl(rl(b))) ^ rl(rl(rl(rl(b)))) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = sb[k[13]] ^ rc;
      tmp[1] = sb[k[14]];
      tmp[2] = sb[k[15]];
      tmp[3] = sb[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ tmp[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[c*4+q] = t[((c+q)%4)*4+q];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
          s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Core model: output valid LATENCY cycles after the inputs become stable.
  always @(posedge clk) begin
    pipe[0] <= aes_enc(aes_key, aes_state);
    for (int i = 1; i < LATENCY-1; i++) pipe[i] <= pipe[i-1];
  end
  assign aes_out = pipe[LATENCY-2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic keep, input bit gaps);
    int g;
    int n;
    bit ok;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    in_data = w;
    in_key_keep = keep;
    in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("in_handshake", 128'(ok), 128'(1));
    in_valid = 1'b0;
    in_key_keep = 1'b0;
  endtask

  task automatic load_block(input logic [127:0] key, input logic [127:0] pt, input bit gaps);
    for (int i = 0; i < 4; i++) send_word(key[127-32*i -: 32], 1'b0, gaps);
    for (int i = 0; i < 4; i++) send_word(pt[127-32*i -: 32], 1'b0, gaps);
    chk("aes_key_loaded", aes_key, key);
    chk("aes_state_loaded", aes_state, pt);
  endtask

  task automatic expect_result(input logic [127:0] ct, input bit bp, input bit hold);
    int n;
    logic [31:0] w;
    if (hold) begin
      in_valid = 1'b1;
      in_data = 32'hdeadbeef;
    end
    n = 0;
    while (!out_valid && n < 300) begin
      chk("wait_in_ready", 128'(in_ready), 128'(0));
      chk("wait_busy", 128'(busy), 128'(1));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(n), 128'(LATENCY));
    for (int i = 0; i < 4; i++) begin
      w = ct[127-32*i -: 32];
      if (bp) begin
        out_ready = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          chk("bp_out_valid", 128'(out_valid), 128'(1));
          chk("bp_out_data", 128'(out_data), 128'(w));
        end
        out_ready = 1'b1;
      end
      chk("out_valid", 128'(out_valid), 128'(1));
      chk("out_data", 128'(out_data), 128'(w));
      chk("drain_in_ready", 128'(in_ready), 128'(0));
      chk("drain_busy", 128'(busy), 128'(1));
      @(posedge clk); #1;
    end
    chk("done_in_ready", 128'(in_ready), 128'(1));
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_out_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] fk, fp, fc, k, p, p2, p3;
    int seen;
    fk = 128'h000102030405060708090a0b0c0d0e0f;
    fp = 128'h00112233445566778899aabbccddeeff;
    fc = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    in_key_keep = 1'b0;
    out_ready = 1'b1;
    build_sbox();
    #12;
    chk("rst_aes_state", aes_state, 128'h0);
    chk("rst_aes_key", aes_key, 128'h0);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_data", 128'(out_data), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 vector
    load_block(fk, fp, 1'b0);
    expect_result(fc, 1'b0, 1'b0);

    // random block, input gaps, valid held through WAIT
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    load_block(k, p, 1'b1);
    expect_result(aes_enc(k, p), 1'b0, 1'b1);

    // random block, output backpressure
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    load_block(k, p, 1'b1);
    expect_result(aes_enc(k, p), 1'b1, 1'b0);

    // reset in the middle of WAIT
    load_block(k, fp, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_aes_state", aes_state, 128'h0);
    chk("mid_rst_aes_key", aes_key, 128'h0);
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    #2 rst = 1'b0;
    seen = 0;
    repeat (LATENCY + 10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_output", 128'(seen), 128'(0));
    load_block(fk, fp, 1'b1);
    expect_result(fc, 1'b0, 1'b0);

    // four words with in_key_keep on the first
    p2 = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) send_word(p2[127-32*i -: 32], i == 0, 1'b0);
`ifdef AES_LOADER_KEY_REUSE_EN
    chk("reuse_key", aes_key, fk);
    chk("reuse_state", aes_state, p2);
    expect_result(aes_enc(fk, p2), 1'b0, 1'b0);
`else
    chk("noreuse_in_ready", 128'(in_ready), 128'(1));
    chk("noreuse_busy", 128'(busy), 128'(0));
    chk("noreuse_key", aes_key, p2);
    p3 = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) send_word(p3[127-32*i -: 32], 1'b0, 1'b0);
    chk("noreuse_state", aes_state, p3);
    expect_result(aes_enc(p2, p3), 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Upstream/downstream I/O stage wrapped around the aes_128 core.
- Assembles 128-bit key and plaintext from a 32-bit valid/ready word stream and drives them onto the core's key/state inputs.
- Waits the core's fixed pipeline latency, captures the ciphertext, then streams it back out as 32-bit words.
- Lets the AES block be driven from a narrow bus, e.g. a UART/FIFO test harness.

Parameters:
- LATENCY, 21, clock cycles from a stable key/state on the core inputs to valid ciphertext on the core output; legal range 1..255.
- CNT_W, 8, width of the latency counter; must hold LATENCY.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  32  input word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- in_key_keep  input  1  reuse the previously loaded key; only used with KEY_REUSE_EN.
- aes_state  output  128  plaintext to the core state input.
- aes_key  output  128  key to the core key input.
- aes_out  input  128  ciphertext from the core.
- out_data  output  32  ciphertext word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts out_data.
- busy  output  1  high in WAIT or DRAIN.

Behaviour:
- FSM states: LOAD, WAIT, DRAIN. Reset state is LOAD.
- Reset values:
  - key_r, state_r, res_r = 0.
  - word_cnt, wait_cnt = 0.
  - Therefore aes_state = 0, aes_key = 0, out_valid = 0, busy = 0.
  - in_ready = 1, since in_ready is decoded combinationally from the state.
- Handshakes: a word transfers on a cycle where valid and ready are both high at the rising clk edge.
- LOAD:
  - in_ready = 1.
  - Words are transferred most-significant word first.
  - Transfers 0-3 load the key: key_r <= {key_r[95:0], in_data}.
  - Transfers 4-7 load the plaintext: state_r <= {state_r[95:0], in_data}.
  - word_cnt increments on each transfer.
  - The transfer at word_cnt = 7 sets word_cnt to 0 and moves to WAIT.
  - in_valid low: no change.
- aes_key and aes_state are driven directly from key_r and state_r. They stay stable through WAIT and DRAIN.
- WAIT:
  - in_ready = 0; in_valid is ignored.
  - wait_cnt increments every cycle.
  - In the cycle where wait_cnt == LATENCY-1: res_r <= aes_out, wait_cnt <= 0, move to DRAIN.
  - Capture happens exactly LATENCY cycles after the first cycle state_r holds the complete block.
- DRAIN:
  - out_valid = 1 and out_data = res_r[127:96].
  - On each transfer: res_r <= {res_r[95:0], 32'h0} and word_cnt increments.
  - The 4th transfer sets word_cnt to 0 and returns to LOAD.
  - out_ready low holds out_data and out_valid stable (no drop, no advance).
- Throughput: one block per 8 + LATENCY + 4 cycles with no backpressure.
- Reset mid-operation: an asserted rst immediately forces the reset values.
  - Any partial load, pending wait or undrained result is discarded.
  - The first transfer after reset is key word 0.
- Re-entering LOAD does not clear key_r or state_r. Old values are shifted out as new words arrive.

Optional Feature:
- Macro: AES_LOADER_KEY_REUSE_EN.
- Defined: if in_key_keep is high on the transfer at word_cnt = 0 in LOAD:
  - That word is taken as plaintext word 0: state_r shifts and word_cnt jumps to 5.
  - key_r is retained unchanged.
  - A block then needs only 4 input words.
  - in_key_keep is sampled only at word_cnt = 0.
- Undefined: in_key_keep is ignored; every block needs 8 words.

Test Plan:
- FIPS-197 vector, LATENCY = 21:
  - Stimulus: send words 00010203, 04050607, 08090a0b, 0c0d0e0f, 00112233, 44556677, 8899aabb, ccddeeff with out_ready = 1.
  - Response: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
  - First out_valid comes 21 cycles after entering WAIT, and busy is high throughout.
- Input gaps and held valid:
  - Stimulus: insert random in_valid gaps; hold in_valid high during WAIT.
  - Response: same ciphertext; no extra word is absorbed; in_ready = 0 for all of WAIT/DRAIN.
- Output backpressure:
  - Stimulus: hold out_ready low for 10 cycles at each word.
  - Response: out_data stays at the current word, four words in order, then return to LOAD with in_ready = 1.
- Reset mid-operation:
  - Stimulus: assert rst at wait_cnt = 10.
  - Response: out_valid never rises; all outputs return to 0.
  - A fresh 8-word load then yields the correct ciphertext.
- Key reuse (AES_LOADER_KEY_REUSE_EN defined):
  - Stimulus: after the vector above, send 4 plaintext words with in_key_keep = 1 on the first one.
  - Response: aes_key stays 000102..0f and the ciphertext matches the software model.
  - With the macro undefined, the same 4 words leave the block still in LOAD at word_cnt = 4.
